// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of one single-port data RAM between the
// processor load/store path (port 0) and the loader/debug path (port 1).
// One access is granted per cycle. Read data is routed back to the requesting
// port through a RD_LAT-deep {valid, port} tag pipeline.
`timescale 1ns/1ps
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_q
);

    // last_gnt: 0 = port 0 was granted most recently, 1 = port 1
    logic              last_gnt_q, last_gnt_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic [RD_LAT-1:0] pipe_valid_q, pipe_valid_d;
    logic [RD_LAT-1:0] pipe_port_q, pipe_port_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
    logic              rd_issue;
    logic              ret_valid;
    logic              ret_port;

    // Round-robin grant: a lone requester wins; on a tie the port that was not
    // granted last wins. Nothing is granted while reset is held.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (!reset) begin
            if (p0_req && (!p1_req || last_gnt_q)) begin
                p0_gnt = 1'b1;
            end else if (p1_req) begin
                p1_gnt = 1'b1;
            end
        end
    end

    // RAM pin mux: granted port drives the pins; otherwise address/data hold
    // their last driven values and the write enable stays low.
    always_comb begin
        mem_addr = mem_addr_q;
        mem_data = mem_data_q;
        mem_wren = 1'b0;
        if (p0_gnt) begin
            mem_addr = p0_addr;
            mem_data = p0_wdata;
            mem_wren = p0_we;
        end else if (p1_gnt) begin
            mem_addr = p1_addr;
            mem_data = p1_wdata;
            mem_wren = p1_we;
        end
    end

    // Read-return routing: the tag leaving the pipeline selects which port sees
    // mem_q; rdata outputs show their last returned word between pulses.
    always_comb begin
        ret_valid = pipe_valid_q[RD_LAT-1] & ~reset;
        ret_port  = pipe_port_q[RD_LAT-1];
        p0_rvalid = ret_valid & ~ret_port;
        p1_rvalid = ret_valid & ret_port;
        p0_rdata  = p0_rvalid ? mem_q : p0_rdata_q;
        p1_rdata  = p1_rvalid ? mem_q : p1_rdata_q;
    end

    // Next-state: arbitration history, held RAM pins, tag pipeline shift and
    // captured read data.
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (p0_gnt) begin
            last_gnt_d = 1'b0;
        end else if (p1_gnt) begin
            last_gnt_d = 1'b1;
        end
        mem_addr_d = mem_addr;
        mem_data_d = mem_data;
        rd_issue   = (p0_gnt & ~p0_we) | (p1_gnt & ~p1_we);
        pipe_valid_d    = pipe_valid_q;
        pipe_port_d     = pipe_port_q;
        pipe_valid_d[0] = rd_issue;
        pipe_port_d[0]  = p1_gnt;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_port_d[i]  = pipe_port_q[i-1];
        end
        p0_rdata_d = p0_rdata;
        p1_rdata_d = p1_rdata;
    end

    // State registers; reset discards in-flight reads and gives port 0 the
    // first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt_q   <= 1'b1;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            pipe_valid_q <= '0;
            pipe_port_q  <= '0;
            p0_rdata_q   <= '0;
            p1_rdata_q   <= '0;
        end else begin
            last_gnt_q   <= last_gnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            pipe_valid_q <= pipe_valid_d;
            pipe_port_q  <= pipe_port_d;
            p0_rdata_q   <= p0_rdata_d;
            p1_rdata_q   <= p1_rdata_d;
        end
    end

endmodule
